// File: rtl/pipe_stage_chain.sv
// N-stage valid/allowin pipeline chain with per-stage stall and flush,
// exposing every stage's contents plus occupancy and input-stall statistics.
module pipe_stage_chain #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  output logic                         in_allowin,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [STAGES-1:0]            stage_ready_go,
  input  logic [STAGES-1:0]            stage_flush,
  output logic                         out_valid,
  input  logic                         out_allowin,
  output logic [WIDTH-1:0]             out_data,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WIDTH-1:0]      stage_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]              stall_q, stall_d;
  logic [STAGES-1:0]             allowin;
  logic [STAGES-1:0]             go;
  logic [STAGES-1:0]             up_valid;
  logic [STAGES-1:0][WIDTH-1:0]  up_data;
  logic [OCC_W-1:0]              occ;

  // allowin ripples from the oldest stage back to the input; a running
  // scalar keeps the vector free of self-dependence.
  always_comb begin : allowin_chain
    logic chain;
    chain   = out_allowin;
    allowin = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      chain = ~valid_q[STAGES-1-k] | (stage_ready_go[STAGES-1-k] & chain);
      allowin[STAGES-1-k] = chain;
    end
  end

  always_comb begin
    go          = valid_q & stage_ready_go & ~stage_flush;
    up_valid    = '0;
    up_data     = '0;
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int unsigned k = 1; k < STAGES; k++) begin
      up_valid[k] = go[k-1];
      up_data[k]  = data_q[k-1];
    end
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      valid_d[k] = allowin[k] ? up_valid[k] : (valid_q[k] & ~stage_flush[k]);
      if (up_valid[k] && allowin[k]) begin
        data_d[k] = up_data[k];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(valid_q[k]);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !allowin[0] && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      data_q  <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

  assign in_allowin  = allowin[0];
  assign out_valid   = go[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;
  assign occupancy   = occ;
  assign stall_cnt   = stall_q;

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised N-stage valid/allowin pipeline chain with a W-bit payload per stage.
- Each stage has its own ready_go stall input and its own flush input.
- All stage contents are exposed so the core top can build hazard and forwarding logic from them.
- It replaces the hand-written per-stage valid/allowin glue between the IF/ID/EX/MEM/WB stages, and adds arbitrary depth, per-stage flush, occupancy and stall statistics.

Parameters:
- STAGES, 4, number of pipeline stages (>=1); stage 0 is youngest, stage STAGES-1 is oldest.
- WIDTH, 32, payload bits per stage.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers an item.
- in_allowin  output  1  stage 0 can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- stage_ready_go  input  STAGES  bit i: stage i has finished its work and may hand its item on.
- stage_flush  input  STAGES  bit i: discard the item currently held in stage i.
- out_valid  output  1  oldest stage offers an item downstream.
- out_allowin  input  1  downstream accepts.
- out_data  output  WIDTH  payload of stage STAGES-1.
- stage_valid  output  STAGES  valid bit of every stage.
- stage_data  output  STAGES*WIDTH  payload of every stage; stage i occupies bits [i*WIDTH +: WIDTH].
- occupancy  output  $clog2(STAGES+1)  number of valid stages.
- stall_cnt  output  CNT_W  cycles in which in_valid=1 and in_allowin=0, saturating.

Behaviour:
- Reset (asynchronous, resetn=0):
  - all valid_i=0, all payload registers=0, stall_cnt=0.
  - Outputs under reset: out_valid=0, occupancy=0, stage_valid=0, stage_data=0, in_allowin=1.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation drops every in-flight item with no drain.
- Combinational terms, per stage i:
  - go_i = valid_i & stage_ready_go[i] & ~stage_flush[i].
  - allowin_i = ~valid_i | (stage_ready_go[i] & allowin_{i+1}), with allowin_STAGES = out_allowin.
  - in_allowin = allowin_0.
  - up_valid_0 = in_valid; up_valid_i = go_{i-1} for i>0.
- out_valid = go_{STAGES-1}; out_data = payload of stage STAGES-1.
- Combinational path from out_allowin through every stage to in_allowin is intentional; no register break.
- Register update on each edge:
  - valid_i <= allowin_i ? up_valid_i : (valid_i & ~stage_flush[i]).
  - payload_i <= up_data_i when (up_valid_i & allowin_i); otherwise it holds.
- Flush rules:
  - Flush kills the item in stage i wherever it would go: it is not forwarded, and out_valid is masked if i = STAGES-1.
  - Flush does not change allowin_i, so a new item from stage i-1 (or from the input) may enter stage i on the same edge.
  - Flushing several stages, e.g. all stages younger than a branch, uses several set bits.
- Stall: a valid stage with ready_go=0 holds its item; younger stages back up only once the bubble reaches them, and older stages keep draining.
- Latency: an item accepted on edge t, with ready_go and out_allowin held at 1, is presented on out_data in the cycle after edge t+STAGES-1. Sustained throughput is 1 item/cycle.
- occupancy: combinational popcount of valid_i.
- stall_cnt:
  - increments on each edge where in_valid & ~in_allowin;
  - saturates at 2^CNT_W-1;
  - cleared only by reset.
- STAGES=1 degenerates to a single handshake register with identical rules.

Test Plan:
- Streaming (STAGES=4, WIDTH=32, all ready_go=1, out_allowin=1), in_data 0x100..0x107 on consecutive cycles:
  - out_data shows 0x100..0x107 in order, first appearing 3 edges after the edge that accepted 0x100, with no bubbles;
  - stall_cnt stays 0.
- Backpressure: out_allowin=0 with continuous in_valid:
  - after 4 accepts, occupancy=4 and in_allowin=0;
  - stall_cnt counts 1,2,3… each further cycle;
  - when out_allowin returns to 1, items resume in order with none lost or duplicated.
- Middle stall: pipe full of A(s3) B(s2) C(s1) D(s0), stage_ready_go[1]=0 for 3 cycles, out_allowin=1:
  - A and B exit on successive cycles;
  - C and D hold and in_allowin=0;
  - stage_valid=4'b0011 after 2 cycles;
  - after release, C then D exit.
- Flush with concurrent entry: pipe full, stage_flush=4'b0011, in_valid=1 with 0xAA:
  - items in s0/s1 are discarded and never reach out_data;
  - s0 holds 0xAA next cycle;
  - s2/s3 advance normally.
- Flush of the oldest stage: stage_flush[3]=1 while out_allowin=1:
  - out_valid=0 that cycle and the item is dropped;
  - occupancy drops by 1 at the edge.
- Async reset mid-stream (occupancy=3, stall_cnt=5), resetn pulsed low between edges:
  - stage_valid=0, occupancy=0, stall_cnt=0, out_valid=0 immediately, without waiting for a clock edge;
  - first post-reset input emerges as in the streaming test.
- Saturation (CNT_W=4): hold in_valid=1 and out_allowin=0 for 30 cycles after fill:
  - stall_cnt reaches 15 and stays at 15.
